gate_test_sequencer: RTL

- Self-checking stimulus engine for any 2-input gate under test (AND/OR/NAND/NOR/XOR/XNOR).
- Sits directly upstream and downstream of the gate: drives dut_a/dut_b through the full truth table and samples dut_c after a settle window.
- Compares each sample against a reference model and reports pass/fail, an error count and the first failing vector.
- Replaces hand-timed delay stimulus with a clocked, repeatable sweep.

---
 rtl/gate_test_sequencer_pkg.sv | 25 ++
 rtl/gate_test_sequencer_ref.sv | 27 ++
 rtl/gate_test_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gate_test_sequencer_pkg.sv
// Shared codes for the 2-input gate test sequencer: function selects,
// FSM states and the sweep length.
package gate_test_sequencer_pkg;

  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_OR   = 3'd1;
  localparam logic [2:0] FN_NAND = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_XNOR = 3'd5;

  localparam int NUM_VECS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic is_valid_fn(input logic [2:0] f);
    return f <= FN_XNOR;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_ref.sv
// Combinational golden model of a 2-input gate, selected by func_sel.
// Also reused by gate benches outside this block.
module gate_ref_model
  import gate_test_sequencer_pkg::*;
(
  input  logic [2:0] func_sel,
  input  logic       a,
  input  logic       b,
  output logic       expected,
  output logic       valid
);

  always_comb begin
    expected = 1'b0;
    valid    = 1'b1;
    case (func_sel)
      FN_AND:  expected = a & b;
      FN_OR:   expected = a | b;
      FN_NAND: expected = ~(a & b);
      FN_NOR:  expected = ~(a | b);
      FN_XOR:  expected = a ^ b;
      FN_XNOR: expected = ~(a ^ b);
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Clocked truth-table sweep of an external 2-input gate: drives {b,a},
// waits a settle window, samples dut_c and accumulates errors.
module gate_test_sequencer
  import gate_test_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func_sel,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic             fail_valid
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int PC_W = $clog2(PASSES + 1);

  state_e           state_q, state_d;
  logic [2:0]       func_q, func_d;
  logic [1:0]       vec_q, vec_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic             skip_q, skip_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [1:0]       fvec_q, fvec_d;
  logic             fvalid_q, fvalid_d;

  logic ref_exp, ref_valid, last_vec, accept;

  gate_ref_model u_ref (
    .func_sel (func_q),
    .a        (vec_q[0]),
    .b        (vec_q[1]),
    .expected (ref_exp),
    .valid    (ref_valid)
  );

  assign last_vec = (vec_q == 2'(NUM_VECS - 1)) && (pcnt_q == PC_W'(PASSES - 1));
  // An invalid select is still accepted, but parks one cycle in IDLE (skip_q)
  // so the done pulse lands in the second cycle after the accept edge.
  assign accept   = (state_q == ST_IDLE) && !skip_q && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      func_q   <= '0;
      vec_q    <= '0;
      scnt_q   <= '0;
      pcnt_q   <= '0;
      skip_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      vec_q    <= vec_d;
      scnt_q   <= scnt_d;
      pcnt_q   <= pcnt_d;
      skip_q   <= skip_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (skip_q)                              state_d = ST_DONE;
        else if (start && is_valid_fn(func_sel)) state_d = ST_SETTLE;
      end
      ST_SETTLE: if (scnt_q == SC_W'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    func_d   = func_q;
    vec_d    = vec_q;
    scnt_d   = scnt_q;
    pcnt_d   = pcnt_q;
    skip_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
    if (accept) begin
      func_d   = func_sel;
      skip_d   = !is_valid_fn(func_sel);
      vec_d    = '0;
      scnt_d   = '0;
      pcnt_d   = '0;
      pass_d   = 1'b0;
      err_d    = '0;
      fvec_d   = '0;
      fvalid_d = 1'b0;
    end else if (state_q == ST_SETTLE) begin
      scnt_d = scnt_q + SC_W'(1);
    end else if (state_q == ST_SAMPLE) begin
      scnt_d = '0;
      if (dut_c != ref_exp) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (!fvalid_q) begin
          fvec_d   = vec_q;
          fvalid_d = 1'b1;
        end
      end
      if (last_vec) begin
        pass_d = (err_d == '0) && ref_valid;
      end else begin
        vec_d = vec_q + 2'd1;
        if (vec_q == 2'(NUM_VECS - 1)) pcnt_d = pcnt_q + PC_W'(1);
      end
    end
  end

  always_comb begin
    busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    done       = (state_q == ST_DONE);
    dut_a      = busy & vec_q[0];
    dut_b      = busy & vec_q[1];
    pass       = pass_q;
    err_count  = err_q;
    fail_vec   = fvec_q;
    fail_valid = fvalid_q;
  end

endmodule
